int_level_sched: RTL and testbench

- Priority interrupt level scheduler for the NORD-10/S interrupt control (card 1058 area).
- Holds the PID (interrupt detect) and PIE (interrupt enable) registers and selects the highest enabled pending level.
- Sequences the change of the current program level (PIL) so that it only happens on the existing PILKL strobe (~SI & T3).
- Also records the previous level (PVL) and flags pending level changes to the microsequencer.

---
 rtl/int_level_sched_if.sv | 37 +++
 rtl/int_level_sched.sv | 124 ++++++++++++
 tb/tb_int_level_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/int_level_sched_if.sv
// rtl/int_level_sched_if.sv - CPU/interrupt-control bundle for the level scheduler
//
// Purpose: groups the interrupt request, register write and level outputs
// of int_level_sched so the scheduler and its driver share one bundle.
// Ports (signals):
//   ION, IRQ, WPID, WPIE, WDATA, GIVEUP, PILKL : driven by master, read by scheduler
//   PIL, PVL, PID, PIE, INTRQ, NLVL, LCHG      : driven by scheduler
interface int_level_sched_if #(
    parameter int NLEV = 16
);
    localparam int LW = $clog2(NLEV);

    logic            ION;
    logic [NLEV-1:0] IRQ;
    logic            WPID;
    logic            WPIE;
    logic [NLEV-1:0] WDATA;
    logic            GIVEUP;
    logic            PILKL;
    logic [LW-1:0]   PIL;
    logic [LW-1:0]   PVL;
    logic [NLEV-1:0] PID;
    logic [NLEV-1:0] PIE;
    logic            INTRQ;
    logic [LW-1:0]   NLVL;
    logic            LCHG;

    modport master (
        output ION, IRQ, WPID, WPIE, WDATA, GIVEUP, PILKL,
        input  PIL, PVL, PID, PIE, INTRQ, NLVL, LCHG
    );

    modport slave (
        input  ION, IRQ, WPID, WPIE, WDATA, GIVEUP, PILKL,
        output PIL, PVL, PID, PIE, INTRQ, NLVL, LCHG
    );
endinterface

// File: rtl/int_level_sched.sv
// rtl/int_level_sched.sv - priority interrupt level scheduler (PID/PIE, PIL sequencing)
//
// Purpose: holds the interrupt detect/enable registers, picks the highest
// enabled pending level and moves the current program level only on PILKL.
// Ports:
//   clk  : system clock
//   MCL  : master clear, synchronous active-high
//   bus  : int_level_sched_if.slave (requests, register writes, level outputs)
module int_level_sched #(
    parameter int NLEV = 16
) (
    input  logic               clk,
    input  logic               MCL,
    int_level_sched_if.slave   bus
);
    localparam int LW = $clog2(NLEV);

    typedef enum logic [1:0] {IDLE, PEND, EXIT} state_t;

    state_t          state_q, state_d;
    logic [NLEV-1:0] pid_q, pid_d;
    logic [NLEV-1:0] pie_q, pie_d;
    logic [LW-1:0]   pil_q, pil_d;
    logic [LW-1:0]   pvl_q, pvl_d;
    logic [LW-1:0]   nlvl_q, nlvl_d;
    logic            lchg_q, lchg_d;
    logic [LW-1:0]   tgt;
    logic            up;

    // Highest enabled pending level; later (higher) bits overwrite lower ones.
    always_comb begin
        tgt = '0;
        for (int i = 0; i < NLEV; i++) begin
            if (pid_q[i] && pie_q[i]) begin
                tgt = LW'(i);
            end
        end
    end

    assign up = (tgt > pil_q);

    // Write is the base, give-up clears the running level, requests win over both.
    always_comb begin
        pid_d = bus.WPID ? bus.WDATA : pid_q;
        if (bus.GIVEUP) begin
            pid_d[pil_q] = 1'b0;
        end
        pid_d = pid_d | bus.IRQ;
        pie_d = bus.WPIE ? bus.WDATA : pie_q;
    end

    always_comb begin
        state_d = state_q;
        nlvl_d  = nlvl_q;
        pil_d   = pil_q;
        pvl_d   = pvl_q;
        lchg_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.GIVEUP) begin
                    state_d = EXIT;
                end else if (bus.ION && up) begin
                    state_d = PEND;
                    nlvl_d  = tgt;
                end
            end
            PEND: begin
                // Track preemption by a higher level until the switch happens.
                if (up) begin
                    nlvl_d = tgt;
                end
                if (bus.GIVEUP) begin
                    state_d = EXIT;
                end else if (!bus.ION || !up) begin
                    state_d = IDLE;
                end else if (bus.PILKL) begin
                    pvl_d   = pil_q;
                    pil_d   = nlvl_q;
                    lchg_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            EXIT: begin
                // Leaving a level may drop to any level, including 0.
                nlvl_d = tgt;
                if (bus.PILKL) begin
                    pvl_d   = pil_q;
                    pil_d   = nlvl_q;
                    lchg_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (MCL) begin
            state_q <= IDLE;
            pid_q   <= '0;
            pie_q   <= '0;
            pil_q   <= '0;
            pvl_q   <= '0;
            nlvl_q  <= '0;
            lchg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            pie_q   <= pie_d;
            pil_q   <= pil_d;
            pvl_q   <= pvl_d;
            nlvl_q  <= nlvl_d;
            lchg_q  <= lchg_d;
        end
    end

    assign bus.PIL   = pil_q;
    assign bus.PVL   = pvl_q;
    assign bus.PID   = pid_q;
    assign bus.PIE   = pie_q;
    assign bus.NLVL  = nlvl_q;
    assign bus.LCHG  = lchg_q;
    assign bus.INTRQ = (state_q == PEND) || (state_q == EXIT);
endmodule

// File: tb/tb_int_level_sched.sv
// tb/tb_int_level_sched.sv - self-checking bench for int_level_sched
module tb_int_level_sched;
    logic clk;
    logic mcl;

    int_level_sched_if #(.NLEV(16)) bus ();

    int_level_sched #(.NLEV(16)) dut (
        .clk (clk),
        .MCL (mcl),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mcl;
        logic        ion;
        logic [15:0] irq;
        logic        wpid;
        logic        wpie;
        logic [15:0] wdata;
        logic        giveup;
        logic        pilkl;
        logic [3:0]  pil;
        logic [3:0]  pvl;
        logic [15:0] pid;
        logic [15:0] pie;
        logic        intrq;
        logic [3:0]  nlvl;
        logic        lchg;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    function automatic vec_t v(logic m, logic ion, logic [15:0] irq, logic wpid, logic wpie,
                               logic [15:0] wd, logic gu, logic kl, logic [3:0] pil,
                               logic [3:0] pvl, logic [15:0] pid, logic [15:0] pie,
                               logic intrq, logic [3:0] nlvl, logic lchg);
        vec_t r;
        r.mcl = m; r.ion = ion; r.irq = irq; r.wpid = wpid; r.wpie = wpie;
        r.wdata = wd; r.giveup = gu; r.pilkl = kl; r.pil = pil; r.pvl = pvl;
        r.pid = pid; r.pie = pie; r.intrq = intrq; r.nlvl = nlvl; r.lchg = lchg;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h expected %h", n_step, name, act, exp);
        end
    endtask

    task automatic run(input vec_t x);
        vec_t e;
        @(negedge clk);
        mcl        = x.mcl;
        bus.ION    = x.ion;
        bus.IRQ    = x.irq;
        bus.WPID   = x.wpid;
        bus.WPIE   = x.wpie;
        bus.WDATA  = x.wdata;
        bus.GIVEUP = x.giveup;
        bus.PILKL  = x.pilkl;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("PIL",   16'(bus.PIL),   16'(e.pil));
        chk("PVL",   16'(bus.PVL),   16'(e.pvl));
        chk("PID",   bus.PID,        e.pid);
        chk("PIE",   bus.PIE,        e.pie);
        chk("INTRQ", 16'(bus.INTRQ), 16'(e.intrq));
        chk("NLVL",  16'(bus.NLVL),  16'(e.nlvl));
        chk("LCHG",  16'(bus.LCHG),  16'(e.lchg));
        n_step++;
    endtask

    // Common lead-in: reset, enable all, request level 10, switch to it.
    task automatic to_level10();
        run(v(1,1,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0000,16'h0000,0, 0,0));
        run(v(0,1,16'h0000,0,1,16'hFFFF,0,0, 0,0,16'h0000,16'hFFFF,0, 0,0));
        run(v(0,1,16'h0400,0,0,16'h0000,0,0, 0,0,16'h0400,16'hFFFF,0, 0,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0400,16'hFFFF,1,10,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,1,10,0,16'h0400,16'hFFFF,0,10,1));
    endtask

    initial begin
        mcl = 1'b1;
        bus.ION = 0; bus.IRQ = '0; bus.WPID = 0; bus.WPIE = 0;
        bus.WDATA = '0; bus.GIVEUP = 0; bus.PILKL = 0;

        //        mcl ion irq     wpid wpie wdata  gu kl  pil pvl pid      pie     intrq nlvl lchg
        // reset with every input busy, then upward switch 0 -> 10
        tbl.push_back(v(1,1,16'hFFFF,1,1,16'hFFFF,1,1,  0,0,16'h0000,16'h0000,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,1,16'hFFFF,0,0,  0,0,16'h0000,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0400,0,0,16'h0000,0,0,  0,0,16'h0400,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0400,16'hFFFF,1,10,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0400,16'hFFFF,1,10,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,1, 10,0,16'h0400,16'hFFFF,0,10,1));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0, 10,0,16'h0400,16'hFFFF,0,10,0));
        // preemption while pending: 5 then 12
        tbl.push_back(v(1,0,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0000,16'h0000,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,1,16'hFFFF,0,0,  0,0,16'h0000,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0020,0,0,16'h0000,0,0,  0,0,16'h0020,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0020,16'hFFFF,1, 5,0));
        tbl.push_back(v(0,1,16'h1000,0,0,16'h0000,0,0,  0,0,16'h1020,16'hFFFF,1, 5,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h1020,16'hFFFF,1,12,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,1, 12,0,16'h1020,16'hFFFF,0,12,1));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0, 12,0,16'h1020,16'hFFFF,0,12,0));
        // same with level 12 disabled
        tbl.push_back(v(1,0,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0000,16'h0000,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,1,16'hEFFF,0,0,  0,0,16'h0000,16'hEFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0020,0,0,16'h0000,0,0,  0,0,16'h0020,16'hEFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0020,16'hEFFF,1, 5,0));
        tbl.push_back(v(0,1,16'h1000,0,0,16'h0000,0,0,  0,0,16'h1020,16'hEFFF,1, 5,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h1020,16'hEFFF,1, 5,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,1,  5,0,16'h1020,16'hEFFF,0, 5,1));
        // cancel by clearing PID, then PILKL in IDLE is ignored
        tbl.push_back(v(1,0,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0000,16'h0000,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,1,16'hFFFF,0,0,  0,0,16'h0000,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0080,0,0,16'h0000,0,0,  0,0,16'h0080,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0080,16'hFFFF,1, 7,0));
        tbl.push_back(v(0,1,16'h0000,1,0,16'h0000,0,0,  0,0,16'h0000,16'hFFFF,1, 7,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0000,16'hFFFF,0, 7,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,1,  0,0,16'h0000,16'hFFFF,0, 7,0));
        // give up level 10 with level 3 pending
        tbl.push_back(v(1,0,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0000,16'h0000,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,1,16'hFFFF,0,0,  0,0,16'h0000,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0400,0,0,16'h0000,0,0,  0,0,16'h0400,16'hFFFF,0, 0,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  0,0,16'h0400,16'hFFFF,1,10,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,1, 10,0,16'h0400,16'hFFFF,0,10,1));
        tbl.push_back(v(0,1,16'h0008,0,0,16'h0000,0,0, 10,0,16'h0408,16'hFFFF,0,10,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,1,0, 10,0,16'h0008,16'hFFFF,1,10,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0, 10,0,16'h0008,16'hFFFF,1, 3,0));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,1,  3,10,16'h0008,16'hFFFF,0, 3,1));
        tbl.push_back(v(0,1,16'h0000,0,0,16'h0000,0,0,  3,10,16'h0008,16'hFFFF,0, 3,0));

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i]);
        end

        // give up with nothing else pending drops to level 0
        to_level10();
        run(v(0,1,16'h0000,0,0,16'h0000,1,0, 10,0,16'h0000,16'hFFFF,1,10,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,0, 10,0,16'h0000,16'hFFFF,1, 0,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,1,  0,10,16'h0000,16'hFFFF,0, 0,1));

        // new request on the level being given up keeps it and reselects it
        to_level10();
        run(v(0,1,16'h0400,0,0,16'h0000,1,0, 10,0,16'h0400,16'hFFFF,1,10,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,0, 10,0,16'h0400,16'hFFFF,1,10,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,1, 10,10,16'h0400,16'hFFFF,0,10,1));
        run(v(0,1,16'h0000,0,0,16'h0000,0,0, 10,10,16'h0400,16'hFFFF,0,10,0));

        // request beats a same-cycle PID write of zero
        run(v(1,1,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0000,16'h0000,0, 0,0));
        run(v(0,1,16'h0000,1,0,16'hFFFF,0,0, 0,0,16'hFFFF,16'h0000,0, 0,0));
        run(v(0,1,16'h0010,1,0,16'h0000,0,0, 0,0,16'h0010,16'h0000,0, 0,0));

        // ION=0 holds off PEND; ION drop cancels even with PILKL; reset beats PILKL
        run(v(1,0,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0000,16'h0000,0, 0,0));
        run(v(0,0,16'h0000,0,1,16'hFFFF,0,0, 0,0,16'h0000,16'hFFFF,0, 0,0));
        run(v(0,0,16'h0100,0,0,16'h0000,0,0, 0,0,16'h0100,16'hFFFF,0, 0,0));
        run(v(0,0,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0100,16'hFFFF,0, 0,0));
        run(v(0,0,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0100,16'hFFFF,0, 0,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0100,16'hFFFF,1, 8,0));
        run(v(0,0,16'h0000,0,0,16'h0000,0,1, 0,0,16'h0100,16'hFFFF,0, 8,0));
        run(v(0,1,16'h0000,0,0,16'h0000,0,0, 0,0,16'h0100,16'hFFFF,1, 8,0));
        run(v(1,1,16'h0000,0,0,16'h0000,0,1, 0,0,16'h0000,16'h0000,0, 0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
